// File: rtl/instr_mem_writer.sv
// ----------------------------------------------------------------------------
// instr_mem_writer
//
// Program-load side of the instruction memory. Decoded MIPS fields are
// re-encoded into 32-bit instruction words, buffered in a small FIFO and
// written to consecutive instruction-memory word addresses, starting at
// BASE_ADDR for every load session. This is the inverse of the fetch/decode
// path and runs before the processor starts executing.
//
// Parameters
//   ADDR_W      instruction-memory word address width
//   DEPTH       number of writable words per session (<= 2**ADDR_W)
//   FIFO_DEPTH  encoded-word buffer entries (power of two, >= 2)
//   BASE_ADDR   first write address of each session
//
// Ports
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_start              one-cycle pulse opening a session (only in IDLE)
//   i_fmt                00=R, 01=I, 10=J, 11=illegal (encodes to zero)
//   i_opcode .. i_target decoded instruction fields
//   i_last               marks the final instruction of the session
//   i_in_valid           fields valid; o_in_ready = writer accepts them
//   o_mem_we             write request, held with addr/data until i_mem_ready
//   o_mem_addr           write word address (saturates at BASE_ADDR+DEPTH-1)
//   o_mem_wdata          encoded instruction word at the FIFO head
//   i_mem_ready          memory accepts the write this cycle
//   o_busy               session active (LOAD or DRAIN)
//   o_done               one-cycle pulse at session end
//   o_count              words written in the current session
//   o_ovf                sticky: data offered after the session was full
//   o_fmt_err            sticky: an illegal format was accepted
//   o_checksum           running XOR of written words (optional)
//
// Optional feature: define INST_WR_CHECKSUM_EN to add o_checksum.
// ----------------------------------------------------------------------------
module instr_mem_writer #(
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [1:0]        i_fmt,
   input  logic [5:0]        i_opcode,
   input  logic [4:0]        i_r_reg1,
   input  logic [4:0]        i_r_reg2,
   input  logic [4:0]        i_w_reg,
   input  logic [4:0]        i_shift,
   input  logic [5:0]        i_funct,
   input  logic [15:0]       i_imm,
   input  logic [25:0]       i_target,
   input  logic              i_last,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   input  logic              i_mem_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W:0]   o_count,
   output logic              o_ovf,
   output logic              o_fmt_err
`ifdef INST_WR_CHECKSUM_EN
   ,
   output logic [31:0]       o_checksum
`endif
);

   localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(BASE_ADDR + DEPTH - 1);
   localparam logic [PTR_W:0]    FULL_C  = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [31:0]       r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_occ;
   logic              r_full;
   logic [ADDR_W:0]   r_accepted;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_busy;
   logic              r_done;
   logic              r_ovf;
   logic              r_fmt_err;
`ifdef INST_WR_CHECKSUM_EN
   logic [31:0]       r_checksum;
`endif

   logic [31:0]       w_enc_word;
   logic              w_in_ready;
   logic              w_mem_we;
   logic [31:0]       w_head;
   logic              w_push;
   logic              w_pop;
   logic [PTR_W:0]    w_occ_next;

   // ------------------------------------------------------------------------
   // Field re-encoding. The illegal format yields an all-zero word so the
   // memory image stays deterministic; the error is flagged separately.
   // ------------------------------------------------------------------------
   always_comb begin
      w_enc_word = 32'h0;
      case (i_fmt)
         2'b00:   w_enc_word = {i_opcode, i_r_reg1, i_r_reg2, i_w_reg, i_shift, i_funct};
         2'b01:   w_enc_word = {i_opcode, i_r_reg1, i_r_reg2, i_imm};
         2'b10:   w_enc_word = {i_opcode, i_target};
         default: w_enc_word = 32'h0;
      endcase
   end

   // Full is taken from a register, so a pop in the same cycle does not open
   // a slot for a push until the following cycle.
   assign w_in_ready = (r_state == S_LOAD) && !r_full && (r_accepted < DEPTH_C);
   assign w_mem_we   = (r_occ != '0);
   assign w_head     = r_fifo[r_rd_ptr];
   assign w_push     = i_in_valid && w_in_ready;
   assign w_pop      = w_mem_we && i_mem_ready;

   always_comb begin
      w_occ_next = r_occ;
      if (w_push && !w_pop) begin
         w_occ_next = r_occ + (PTR_W+1)'(1);
      end else if (!w_push && w_pop) begin
         w_occ_next = r_occ - (PTR_W+1)'(1);
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage: no reset, contents are qualified by the occupancy count.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= w_enc_word;
      end
   end

   // ------------------------------------------------------------------------
   // Control: FIFO pointers, write address, counters and session FSM.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_full     <= 1'b0;
         r_accepted <= '0;
         r_count    <= '0;
         r_mem_addr <= BASE_C;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_fmt_err  <= 1'b0;
`ifdef INST_WR_CHECKSUM_EN
         r_checksum <= 32'h0;
`endif
      end else begin
         r_done <= 1'b0;
         r_occ  <= w_occ_next;
         r_full <= (w_occ_next == FULL_C);

         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            r_accepted <= r_accepted + (ADDR_W+1)'(1);
            if (i_fmt == 2'b11) begin
               r_fmt_err <= 1'b1;
            end
         end

         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count  <= r_count + (ADDR_W+1)'(1);
            // Hold at the last legal address rather than wrapping.
            if (r_mem_addr != LAST_C) begin
               r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end
`ifdef INST_WR_CHECKSUM_EN
            r_checksum <= r_checksum ^ w_head;
`endif
         end

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_LOAD;
                  r_busy     <= 1'b1;
                  r_count    <= '0;
                  r_ovf      <= 1'b0;
                  r_fmt_err  <= 1'b0;
                  r_accepted <= '0;
                  r_mem_addr <= BASE_C;
`ifdef INST_WR_CHECKSUM_EN
                  r_checksum <= 32'h0;
`endif
               end
            end
            S_LOAD: begin
               if (w_push && i_last) begin
                  r_state <= S_DRAIN;
               end else if (r_accepted == DEPTH_C) begin
                  // Session is full; anything still offered is lost.
                  r_state <= S_DRAIN;
                  if (i_in_valid) begin
                     r_ovf <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (!w_mem_we) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_mem_we    = w_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = w_head;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_count     = r_count;
   assign o_ovf       = r_ovf;
   assign o_fmt_err   = r_fmt_err;
`ifdef INST_WR_CHECKSUM_EN
   assign o_checksum  = r_checksum;
`endif

endmodule

// File: doc/instr_mem_writer.md
Name: instr_mem_writer

Overview:
- Program-load side of the instruction memory: accepts decoded MIPS fields (opcode, r_reg1, r_reg2, w_reg, shift, funct, imm, target) and re-encodes them into 32-bit instruction words.
- Buffers the words in a small FIFO and writes them to consecutive instruction-memory addresses over a write port with a ready handshake.
- Performs the inverse of the instruction fetch/decode path; used by the program loader ahead of processor execution.

Parameters:
- ADDR_W, 8, width of the instruction memory word address.
- DEPTH, 256, number of writable words (must be ≤ 2^ADDR_W).
- FIFO_DEPTH, 4, number of encoded-word buffer entries (power of 2, ≥ 2).
- BASE_ADDR, 0, first write address of each load session.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that opens a load session. Ignored unless in IDLE.
- fmt  in  2  instruction format: 00=R, 01=I, 10=J, 11=illegal.
- opcode  in  6  opcode field.
- r_reg1  in  5  rs field.
- r_reg2  in  5  rt field.
- w_reg  in  5  rd field.
- shift  in  5  shamt field.
- funct  in  6  funct field.
- imm  in  16  I-type immediate.
- target  in  26  J-type target.
- last  in  1  qualifies the final instruction of the session.
- in_valid  in  1  fields valid.
- in_ready  out  1  writer accepts fields this cycle.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  session active (LOAD or DRAIN).
- done  out  1  one-cycle pulse at session end.
- count  out  ADDR_W+1  words written in the current session.
- ovf  out  1  sticky: data offered after memory full.
- fmt_err  out  1  sticky: illegal fmt accepted.

Behaviour:
- Reset values: all outputs 0, mem_addr=BASE_ADDR, FIFO empty, state IDLE.
- Reset is asynchronous and may occur mid-session. It flushes the FIFO, drops mem_we immediately, and produces no done pulse.
- Encoding:
  - R: {opcode, r_reg1, r_reg2, w_reg, shift, funct}.
  - I: {opcode, r_reg1, r_reg2, imm}.
  - J: {opcode, target}.
  - 11: word 32'h0, and fmt_err is set.
  - The encoded word is registered into the FIFO on accept.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==LOAD) && !fifo_full && (accepted < DEPTH).
  - fifo_full is registered; a pop in the same cycle does not free a slot for a push.
- Write side:
  - mem_we=1 whenever the FIFO is non-empty. mem_addr and mem_wdata show the FIFO head.
  - mem_addr, mem_wdata and mem_we stay stable until mem_ready=1.
  - On mem_we && mem_ready: pop, mem_addr+1, count+1.
  - Minimum latency is one cycle from accept to mem_we; throughput is one word per cycle.
- FSM:
  - IDLE: on start, go to LOAD. Clear count, ovf and fmt_err; set accepted=0 and mem_addr=BASE_ADDR.
  - LOAD: on accept with last=1, go to DRAIN. When accepted reaches DEPTH, go to DRAIN; if in_valid is high while accepted==DEPTH, set ovf.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- start while busy has no effect.
- busy = LOAD or DRAIN.
- mem_addr never exceeds BASE_ADDR+DEPTH-1 and never wraps.
- Simultaneous push and pop with the FIFO non-full: both occur and occupancy is unchanged.

Optional Feature:
- Macro: INST_WR_CHECKSUM_EN.
- Defined: adds output checksum [31:0], the running XOR of every word written (on mem_we && mem_ready). It is cleared on start and on reset, and is valid at the done pulse.
- Undefined: the checksum port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset; start; one R-type (opcode 0, r_reg1 1, r_reg2 2, w_reg 3, shift 0, funct 0x20, last=1), mem_ready=1 -> mem_we at addr 0 with 0x00221820; done pulses once; count=1.
- Stream with mem_ready=1: I-type (opcode 0x08, rs 1, rt 2, imm 0x0005), then J-type (opcode 0x02, target 0x0000010, last) -> words 0x20220005 and 0x08000010 at addrs 0 and 1 on consecutive cycles; count=2.
- Backpressure: mem_ready=0; push 6 words -> in_ready drops after FIFO_DEPTH=4 accepts with mem_addr/mem_wdata held. Release mem_ready -> all 6 written to addrs 0..5 in order; no loss or duplicate.
- DEPTH=4, push 5 with in_valid held -> exactly 4 writes (addrs 0..3); ovf=1; done pulses; count=4.
- fmt=11 accepted -> mem_wdata=0 written; fmt_err=1 until next start.
- rst_n low mid-DRAIN with 2 words buffered -> mem_we=0 at once, no done; after release: IDLE, count=0, and a new start begins at BASE_ADDR.
